// File: rtl/load_store_pkg.sv
// rtl/load_store_pkg.sv - shared load-path types, size encodings and helpers
// Contents: FSM state enum, LS_* load-size codes, size_bytes() byte-count helper.
package load_store_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH0,
    WAIT0,
    FETCH1,
    WAIT1,
    DONE
  } lae_state_t;

  localparam logic [1:0] LS_BYTE   = 2'd0;
  localparam logic [1:0] LS_HALF   = 2'd1;
  localparam logic [1:0] LS_WORD   = 2'd2;
  localparam logic [1:0] LS_DOUBLE = 2'd3;

  // Number of bytes touched by a load of the given size code (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/load_align_extend_if.sv
// rtl/load_align_extend_if.sv - request, memory-fetch and result bundle of the load aligner
// Signals: req_* (load request in), mem_req_*/mem_rsp_* (word fetch out / data back),
//          out_* (extended result out).
// Modports: slave = the load aligner, master = the requester/memory side driving it.
interface load_align_extend_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
);

  logic                  req_valid;
  logic                  req_ready;
  logic [OFF_W-1:0]      req_off;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [4:0]            req_rd;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_next;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [4:0]            out_rd;
  logic                  out_err;

  modport slave (
    input  req_valid, req_off, req_size, req_unsigned, req_rd,
    output req_ready,
    output mem_req_valid, mem_req_next,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output out_valid, out_data, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output req_valid, req_off, req_size, req_unsigned, req_rd,
    input  req_ready,
    input  mem_req_valid, mem_req_next,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  out_valid, out_data, out_rd, out_err,
    output out_ready
  );

endinterface

// File: rtl/load_extract.sv
// rtl/load_extract.sv - combinational align-and-extend datapath for loads
// Ports: word0/word1 (base and following memory word), off (byte offset),
//        size (LS_* code), is_unsigned (zero- vs sign-extend), data (aligned result).
module load_extract
  import load_store_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] word0,
  input  logic [DATA_WIDTH-1:0] word1,
  input  logic [OFF_W-1:0]      off,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic [6:0]            kept_bits;
  logic                  fill;

  always_comb begin
    // Bytes beyond the top of word0 come from word1, so shift the pair as one.
    shifted   = DATA_WIDTH'({word1, word0} >> {off, 3'b000});
    kept_bits = {size_bytes(size), 3'b000};
    // A shift of DATA_WIDTH or more yields zero, so full-width loads keep every bit.
    keep_mask = ~({DATA_WIDTH{1'b1}} << kept_bits);

    case (size)
      LS_BYTE: fill = shifted[7];
      LS_HALF: fill = shifted[15];
      LS_WORD: fill = shifted[31];
      default: fill = shifted[DATA_WIDTH-1];
    endcase
    fill = fill & ~is_unsigned;

    data = (shifted & keep_mask) | ({DATA_WIDTH{fill}} & ~keep_mask);
  end

endmodule

// File: rtl/load_align_extend.sv
// rtl/load_align_extend.sv - load sequencer: fetches one or two words, aligns and extends
// Ports: clk, rst_n (async active-low), bus (load_align_extend_if.slave):
//        req_* load request, mem_req_*/mem_rsp_* word fetch, out_* registered result.
module load_align_extend
  import load_store_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic               clk,
  input  logic               rst_n,
  load_align_extend_if.slave bus
);

  localparam logic [4:0] WORD_BYTES = 5'(DATA_WIDTH / 8);
  localparam bit         HAS_DOUBLE = (DATA_WIDTH == 64);

  lae_state_t            state;
  logic [OFF_W-1:0]      off_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [4:0]            rd_q;
  logic [DATA_WIDTH-1:0] word0;
  logic [DATA_WIDTH-1:0] word1;

  logic                  req_ready_q;
  logic                  mem_req_valid_q;
  logic                  mem_req_next_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [4:0]            out_rd_q;
  logic                  out_err_q;

  logic                  illegal_size;
  logic                  spans;
  logic [DATA_WIDTH-1:0] ext_word0;
  logic [DATA_WIDTH-1:0] ext_word1;
  logic [DATA_WIDTH-1:0] ext_data;

  assign illegal_size = (bus.req_size == LS_DOUBLE) && !HAS_DOUBLE;
  assign spans        = (5'(off_q) + 5'(size_bytes(size_q))) > WORD_BYTES;

  // The result is registered on the same edge the last word arrives, so feed the
  // extractor straight from the response bus while that word is being captured.
  assign ext_word0 = (state == WAIT0) ? bus.mem_rsp_data : word0;
  assign ext_word1 = (state == WAIT1) ? bus.mem_rsp_data : word1;

  load_extract #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_extract (
    .word0       (ext_word0),
    .word1       (ext_word1),
    .off         (off_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      off_q           <= '0;
      size_q          <= '0;
      unsigned_q      <= 1'b0;
      rd_q            <= '0;
      word0           <= '0;
      word1           <= '0;
      req_ready_q     <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_next_q  <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      out_rd_q        <= '0;
      out_err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            off_q       <= bus.req_off;
            size_q      <= bus.req_size;
            unsigned_q  <= bus.req_unsigned;
            rd_q        <= bus.req_rd;
            word0       <= '0;
            word1       <= '0;
            if (illegal_size) begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b1;
              out_data_q  <= '0;
              out_rd_q    <= bus.req_rd;
            end else begin
              state           <= FETCH0;
              mem_req_valid_q <= 1'b1;
              mem_req_next_q  <= 1'b0;
            end
          end
        end

        FETCH0: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT0;
          end
        end

        WAIT0: begin
          if (bus.mem_rsp_valid) begin
            word0 <= bus.mem_rsp_data;
            if (spans) begin
              state           <= FETCH1;
              mem_req_valid_q <= 1'b1;
              mem_req_next_q  <= 1'b1;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_err_q   <= 1'b0;
              out_data_q  <= ext_data;
              out_rd_q    <= rd_q;
            end
          end
        end

        FETCH1: begin
          if (bus.mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state           <= WAIT1;
          end
        end

        WAIT1: begin
          if (bus.mem_rsp_valid) begin
            word1       <= bus.mem_rsp_data;
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_err_q   <= 1'b0;
            out_data_q  <= ext_data;
            out_rd_q    <= rd_q;
          end
        end

        DONE: begin
          // req_ready rises with the return to IDLE, one cycle after the retire.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_next  = mem_req_next_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_err       = out_err_q;

endmodule

// File: tb/tb_load_align_extend.sv
// tb/tb_load_align_extend.sv - self-checking bench for load_align_extend (32- and 64-bit instances)
module tb_load_align_extend;
  import load_store_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  load_align_extend_if #(.DATA_WIDTH(32)) b32 ();
  load_align_extend_if #(.DATA_WIDTH(64)) b64 ();

  load_align_extend #(.DATA_WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  load_align_extend #(.DATA_WIDTH(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64.slave));

  // Shared stimulus, steered to the selected instance.
  logic        sel64;
  logic        t_req_valid, t_uns, t_mem_req_ready, t_mem_rsp_valid, t_out_ready;
  logic [2:0]  t_off;
  logic [1:0]  t_size;
  logic [4:0]  t_rd;
  logic [63:0] t_rsp_data;

  assign b32.req_valid     = t_req_valid & ~sel64;
  assign b64.req_valid     = t_req_valid & sel64;
  assign b32.req_off       = t_off[1:0];
  assign b64.req_off       = t_off;
  assign b32.req_size      = t_size;
  assign b64.req_size      = t_size;
  assign b32.req_unsigned  = t_uns;
  assign b64.req_unsigned  = t_uns;
  assign b32.req_rd        = t_rd;
  assign b64.req_rd        = t_rd;
  assign b32.mem_req_ready = t_mem_req_ready;
  assign b64.mem_req_ready = t_mem_req_ready;
  assign b32.mem_rsp_valid = t_mem_rsp_valid & ~sel64;
  assign b64.mem_rsp_valid = t_mem_rsp_valid & sel64;
  assign b32.mem_rsp_data  = t_rsp_data[31:0];
  assign b64.mem_rsp_data  = t_rsp_data;
  assign b32.out_ready     = t_out_ready;
  assign b64.out_ready     = t_out_ready;

  logic        o_req_ready, o_mem_req_valid, o_mem_req_next, o_out_valid, o_out_err;
  logic [63:0] o_out_data;
  logic [4:0]  o_out_rd;

  assign o_req_ready     = sel64 ? b64.req_ready     : b32.req_ready;
  assign o_mem_req_valid = sel64 ? b64.mem_req_valid : b32.mem_req_valid;
  assign o_mem_req_next  = sel64 ? b64.mem_req_next  : b32.mem_req_next;
  assign o_out_valid     = sel64 ? b64.out_valid     : b32.out_valid;
  assign o_out_err       = sel64 ? b64.out_err       : b32.out_err;
  assign o_out_data      = sel64 ? b64.out_data      : {32'd0, b32.out_data};
  assign o_out_rd        = sel64 ? b64.out_rd        : b32.out_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: build the little-endian byte image of the two words, pick the bytes
  // of the load, then extend.
  function automatic logic [63:0] ref_load(input bit wide, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns,
                                           input logic [63:0] w0, input logic [63:0] w1);
    logic [7:0]  img [16];
    logic [63:0] r;
    int wb, nb;
    wb = wide ? 8 : 4;
    nb = 1 << size;
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    for (int i = 0; i < wb; i++) begin
      img[i]      = w0[8*i +: 8];
      img[wb + i] = w1[8*i +: 8];
    end
    r = 64'd0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = img[int'(off) + i];
    if (!uns && nb < wb && r[8*nb - 1])
      for (int i = 8 * nb; i < 64; i++) r[i] = 1'b1;
    if (!wide) r[63:32] = 32'd0;
    if (!wide && size == LS_DOUBLE) r = 64'd0;
    return r;
  endfunction

  task automatic load(input bit wide, input logic [2:0] off, input logic [1:0] size,
                      input logic uns, input logic [4:0] rd,
                      input logic [63:0] w0, input logic [63:0] w1,
                      input int mem_stall, input int out_stall, input bit noise,
                      input bit abort_wait1, input string tag);
    int wb, nb, exp_fetch, exp_lat, cyc, acc_cyc, hs_cyc, fetches, unstable, mstall, ostall, vcnt;
    logic [63:0] exp_data, got_data, held_data;
    logic [4:0]  got_rd, held_rd;
    logic        got_err, held_err, exp_err, pending, pend_next, accepted, seen_v;
    logic [1:0]  seq, exp_seq;

    wb        = wide ? 8 : 4;
    nb        = 1 << size;
    exp_err   = !wide && (size == LS_DOUBLE);
    exp_data  = ref_load(wide, off, size, uns, w0, w1);
    exp_fetch = exp_err ? 0 : ((int'(off) + nb > wb) ? 2 : 1);
    exp_lat   = exp_err ? 1 : ((exp_fetch == 2) ? 5 : 3);
    exp_seq   = (exp_fetch == 0) ? 2'b11 : ((exp_fetch == 1) ? 2'b10 : 2'b01);

    sel64 = wide; t_off = off; t_size = size; t_uns = uns; t_rd = rd;
    t_req_valid = 1'b1; t_out_ready = 1'b0;
    mstall = mem_stall; ostall = out_stall;
    cyc = 0; acc_cyc = -1; hs_cyc = -1; fetches = 0; unstable = 0;
    pending = 1'b0; pend_next = 1'b0; accepted = 1'b0; seen_v = 1'b0; seq = 2'b11;
    got_data = '0; got_rd = '0; got_err = 1'b0; held_data = '0; held_rd = '0; held_err = 1'b0;

    while (hs_cyc < 0 && cyc < 100) begin
      if (o_out_valid) begin
        if (seen_v && (o_out_data !== held_data || o_out_rd !== held_rd || o_out_err !== held_err))
          unstable++;
        seen_v = 1'b1; held_data = o_out_data; held_rd = o_out_rd; held_err = o_out_err;
      end
      // Zero-wait memory: data arrives the cycle after the fetch is accepted; when
      // nothing is owed, optionally wiggle rsp_valid with junk to prove it is ignored.
      t_mem_rsp_valid = pending ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      t_rsp_data      = pending ? (pend_next ? w1 : w0) : {$urandom, $urandom};
      if (o_out_valid && ostall > 0) begin t_out_ready = 1'b0; ostall--; end
      else t_out_ready = 1'b1;
      if (o_mem_req_valid && mstall > 0) begin t_mem_req_ready = 1'b0; mstall--; end
      else t_mem_req_ready = 1'b1;

      if (t_req_valid && o_req_ready) begin acc_cyc = cyc; accepted = 1'b1; end
      pending = 1'b0;
      if (o_mem_req_valid && t_mem_req_ready) begin
        fetches++; pending = 1'b1; pend_next = o_mem_req_next; seq = {seq[0], o_mem_req_next};
      end
      if (o_out_valid && t_out_ready) begin
        hs_cyc = cyc; got_data = o_out_data; got_rd = o_out_rd; got_err = o_out_err;
      end
      @(posedge clk); @(negedge clk); cyc++;
      if (accepted) t_req_valid = 1'b0;

      if (abort_wait1 && fetches == 2 && pending) begin
        check({tag, "/no_valid_before_rst"}, 64'(seen_v), 64'd0);
        t_mem_rsp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check({tag, "/rst_out_valid"}, 64'(o_out_valid), 64'd0);
        check({tag, "/rst_mem_req_valid"}, 64'(o_mem_req_valid), 64'd0);
        check({tag, "/rst_req_ready"}, 64'(o_req_ready), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (o_out_valid) vcnt++;
        end
        check({tag, "/valid_after_rst"}, 64'(vcnt), 64'd0);
        check({tag, "/req_ready_after_rst"}, 64'(o_req_ready), 64'd1);
        return;
      end
    end
    t_req_valid = 1'b0; t_out_ready = 1'b0; t_mem_rsp_valid = 1'b0;

    check({tag, "/handshake"}, 64'(hs_cyc >= 0), 64'd1);
    check({tag, "/data"}, got_data, exp_data);
    check({tag, "/rd"}, 64'(got_rd), 64'(rd));
    check({tag, "/err"}, 64'(got_err), 64'(exp_err));
    check({tag, "/fetches"}, 64'(fetches), 64'(exp_fetch));
    check({tag, "/next_order"}, 64'(seq), 64'(exp_seq));
    check({tag, "/latency"}, 64'(hs_cyc - acc_cyc),
          64'(exp_lat + ((exp_fetch > 0) ? mem_stall : 0) + out_stall));
    check({tag, "/stable"}, 64'(unstable), 64'd0);
    check({tag, "/valid_dropped"}, 64'(o_out_valid), 64'd0);
    check({tag, "/req_ready_back"}, 64'(o_req_ready), 64'd1);
  endtask

  initial begin
    logic        wide, uns;
    logic [1:0]  size;
    logic [2:0]  off;

    rst_n = 1'b0; sel64 = 1'b0;
    t_req_valid = 1'b0; t_uns = 1'b0; t_mem_req_ready = 1'b0; t_mem_rsp_valid = 1'b0;
    t_out_ready = 1'b0; t_off = '0; t_size = '0; t_rd = '0; t_rsp_data = '0;
    repeat (2) @(negedge clk);

    check("rst32/req_ready", 64'(o_req_ready), 64'd0);
    check("rst32/mem_req_valid", 64'(o_mem_req_valid), 64'd0);
    check("rst32/out_valid", 64'(o_out_valid), 64'd0);
    check("rst32/out_data", o_out_data, 64'd0);
    check("rst32/out_rd_err", {58'd0, o_out_rd, o_out_err}, 64'd0);
    sel64 = 1'b1; #1;
    check("rst64/out_valid", 64'(o_out_valid), 64'd0);
    check("rst64/out_data", o_out_data, 64'd0);
    sel64 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst32/req_ready_after", 64'(o_req_ready), 64'd1);
    sel64 = 1'b1; #1;
    check("rst64/req_ready_after", 64'(o_req_ready), 64'd1);
    sel64 = 1'b0;

    load(0, 3'd1, LS_BYTE, 0, 5'd3, 64'h80FF7F01, 64'h0, 0, 0, 0, 0, "sb_off1");
    load(0, 3'd2, LS_BYTE, 1, 5'd4, 64'h80FF7F01, 64'h0, 0, 0, 0, 0, "ub_off2");
    load(0, 3'd2, LS_BYTE, 0, 5'd5, 64'h80FF7F01, 64'h0, 0, 0, 0, 0, "sb_off2");
    load(0, 3'd3, LS_HALF, 0, 5'd6, 64'h80112233, 64'hAABBCC44, 0, 0, 0, 0, "sh_span");
    load(1, 3'd4, LS_WORD, 0, 5'd7, 64'h80000000_00000000, 64'h0, 0, 0, 0, 0, "sw64_off4");
    load(1, 3'd4, LS_WORD, 1, 5'd8, 64'h80000000_00000000, 64'h0, 0, 0, 0, 0, "uw64_off4");
    load(0, 3'd0, LS_DOUBLE, 0, 5'd9, 64'h12345678, 64'h0, 0, 0, 0, 0, "illegal_dbl");
    load(0, 3'd0, LS_WORD, 0, 5'd10, 64'hDEADBEEF, 64'h0, 0, 0, 0, 0, "full32");
    load(1, 3'd0, LS_DOUBLE, 0, 5'd11, 64'h8123456789ABCDEF, 64'h0, 0, 0, 0, 0, "full64");
    load(0, 3'd0, LS_WORD, 1, 5'd12, 64'hCAFEF00D, 64'h0, 2, 4, 0, 0, "stall");
    load(0, 3'd3, LS_WORD, 0, 5'd13, 64'h11223344, 64'h55667788, 0, 0, 0, 1, "rst_wait1");
    load(0, 3'd3, LS_WORD, 0, 5'd14, 64'h11223344, 64'h55667788, 0, 0, 0, 0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      wide = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      off  = wide ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      uns  = 1'($urandom_range(0, 1));
      load(wide, off, size, uns, 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           $urandom_range(0, 2), $urandom_range(0, 2), 1, 0, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_align_extend.md
LOAD_ALIGN_EXTEND -- requirements
Module: load_align_extend

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the memory word and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter OFF_W, default $clog2(DATA_WIDTH/8), giving the byte-offset width.
REQ-003 The block SHALL have the port clk  input  1  which is the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have the port rst_n  input  1  which is the asynchronous, active-low reset.
REQ-005 The block SHALL have the port req_valid / req_ready  in / out  1 / 1  which is the load-request handshake.
REQ-006 The block SHALL have the port req_off  input  OFF_W  which is the byte offset of the load within the word.
REQ-007 The block SHALL have the port req_size  input  2  which encodes 0 byte, 1 half, 2 word, 3 double.
REQ-008 The block SHALL have the port req_unsigned  input  1  which selects zero-extension when 1 and sign-extension when 0.
REQ-009 The block SHALL have the port req_rd  input  5  which is the destination tag, returned unchanged.
REQ-010 The block SHALL have the port mem_req_valid / mem_req_ready  out / in  1 / 1  which is the word-fetch handshake.
REQ-011 The block SHALL have the port mem_req_next  output  1  which is 0 for the base word and 1 for the following word.
REQ-012 The block SHALL have the port mem_rsp_valid / mem_rsp_data  input  1 / DATA_WIDTH  which is the fetched-word return, one response per accepted fetch, in order.
REQ-013 The block SHALL have the port out_valid / out_ready  out / in  1 / 1  which is the result handshake.
REQ-014 The block SHALL have the port out_data / out_rd / out_err  output  DATA_WIDTH / 5 / 1  which carries the extended result, the tag, and the illegal-size flag.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH0, WAIT0, FETCH1, WAIT1 and DONE.
REQ-016 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted when req_valid && req_ready, capturing off, size, unsigned and rd, then moving to FETCH0.
REQ-017 For an illegal size (size 3 with DATA_WIDTH 32), the block SHALL go IDLE->DONE with out_err=1, out_data=0 and no fetch.
REQ-018 In FETCH0, mem_req_valid SHALL be 1 with mem_req_next=0, and the block SHALL move to WAIT0 when mem_req_ready.
REQ-019 In WAIT0, mem_rsp_data SHALL be captured into word0 when mem_rsp_valid.
REQ-020 From WAIT0, the block SHALL go to FETCH1 if off + 2^size > DATA_WIDTH/8 (the load spans two words), else to DONE.
REQ-021 FETCH1 and WAIT1 SHALL behave as FETCH0 and WAIT0 with mem_req_next=1, capture word1, then go to DONE.
REQ-022 The result SHALL be {word1, word0} shifted right by 8*off, with the low 8*2^size bits kept and the upper bits filled with zero (unsigned) or copies of the top kept bit (signed).
REQ-023 A full-width load SHALL pass through unextended.
REQ-024 The result SHALL be registered on entry to DONE.
REQ-025 In DONE, out_valid SHALL be 1 and out_data, out_rd and out_err SHALL hold stable until out_ready, then the block SHALL return to IDLE.
REQ-026 A new request SHALL not be accepted in the same cycle as DONE retires, so req_ready rises the cycle after.
REQ-027 Minimum latency from accept to out_valid SHALL be 3 cycles for an aligned load and 5 cycles for a spanning load, each with zero-wait memory.
REQ-028 Back-pressure on mem_req_ready or out_ready SHALL stall the FSM in its state indefinitely, with no loss or duplication of data.
REQ-029 mem_rsp_valid outside WAIT0 or WAIT1 SHALL be ignored.

Reset
REQ-030 Asserting rst_n low SHALL immediately force the state to IDLE, all outputs to 0 (req_ready 1 after release), and word0, word1 and captured fields to 0.
REQ-031 Reset mid-operation SHALL abandon the load without emitting out_valid.

Structure
REQ-032 The state enum, the load-size encodings (LS_BYTE, LS_HALF, LS_WORD, LS_DOUBLE) and a size_bytes function SHALL reside in the shared package load_store_pkg.
REQ-033 The combinational align-and-extend datapath SHALL be one sub-module, load_extract, and the FSM SHALL be in load_align_extend.

Verification
REQ-034 With DATA_WIDTH 32, word0=0x80FF7F01, a signed byte at off 1 -> out_data 0x0000007F; an unsigned byte at off 2 -> 0x000000FF; a signed byte at off 2 -> 0xFFFFFFFF.
REQ-035 With DATA_WIDTH 32, a signed half at off 3, word0=0x80112233 and word1=0xAABBCC44 -> two fetches with mem_req_next 0 then 1, and out_data 0x00004480.
REQ-036 With DATA_WIDTH 64, a signed word at off 4 and word0=0x80000000_00000000 -> out_data 0xFFFFFFFF_80000000; the same load unsigned -> 0x00000000_80000000.
REQ-037 With DATA_WIDTH 32 and req_size 3 -> no mem_req_valid, out_err=1 and out_data=0 on the next cycle.
REQ-038 When out_ready is held low 4 cycles and mem_req_ready is low 2 cycles -> outputs are stable throughout, exactly one out handshake occurs, and latency grows by 6.
REQ-039 When rst_n is pulsed low in WAIT1 -> the state is IDLE, no out_valid is seen, and the next request completes correctly.
